// File: rtl/signal_width_meter_if.sv
// rtl/signal_width_meter_if.sv - pulse input, classification window and result bundle for signal_width_meter
interface signal_width_meter_if #(
    parameter int CNT_W  = 10,
    parameter int PCNT_W = 16
);
    logic              din;
    logic              enable;
    logic [CNT_W-1:0]  min_width;
    logic [CNT_W-1:0]  max_width;
    logic [CNT_W-1:0]  width_out;
    logic              width_valid;
    logic              accept;
    logic              reject_short;
    logic              reject_long;
    logic              busy;
    logic [PCNT_W-1:0] pulse_cnt;

    modport master (
        output din, enable, min_width, max_width,
        input  width_out, width_valid, accept, reject_short, reject_long, busy, pulse_cnt
    );

    modport slave (
        input  din, enable, min_width, max_width,
        output width_out, width_valid, accept, reject_short, reject_long, busy, pulse_cnt
    );
endinterface

// File: rtl/signal_width_meter.sv
// rtl/signal_width_meter.sv - measures din high width in clk cycles and classifies it against a window
// Optional SIGNALWIDTH_DEADTIME_EN adds a deadtime input and a DEAD holdoff state after each measurement.
module signal_width_meter #(
    parameter int CNT_W  = 10,
    parameter int PCNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SIGNALWIDTH_DEADTIME_EN
    input  logic [CNT_W-1:0] deadtime,
`endif
    signal_width_meter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MEASURE, OVER, DEAD} state_t;

    state_t            state, state_n;
    logic              s1, s2, s3;
    logic              rise, fall;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CNT_W-1:0]  width_q, width_n;
    logic              wv_q, wv_n;
    logic              acc_q, acc_n;
    logic              rs_q, rs_n;
    logic              rl_q, rl_n;
    logic              busy_q;
    logic [PCNT_W-1:0] pcnt_q;
    state_t            done_state;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // cnt doubles as the holdoff counter in DEAD, so it restarts at 1 on entry
`ifdef SIGNALWIDTH_DEADTIME_EN
    assign done_state = (deadtime != '0) ? DEAD : IDLE;
`else
    assign done_state = IDLE;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        width_n = width_q;
        wv_n    = 1'b0;
        acc_n   = 1'b0;
        rs_n    = 1'b0;
        rl_n    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable && rise) begin
                    state_n = MEASURE;
                    cnt_n   = CNT_W'(1);
                end
            end
            MEASURE: begin
                if (!bus.enable) begin
                    state_n = IDLE;
                end else if (fall) begin
                    width_n = cnt;
                    wv_n    = 1'b1;
                    acc_n   = (cnt >= bus.min_width);
                    rs_n    = (cnt < bus.min_width);
                    state_n = done_state;
                    cnt_n   = CNT_W'(1);
                end else if ((bus.max_width != '0) && (cnt >= bus.max_width)) begin
                    // still high after max_width cycles: report long now, ignore the eventual fall
                    width_n = bus.max_width;
                    wv_n    = 1'b1;
                    rl_n    = 1'b1;
                    state_n = OVER;
                end else if (cnt != '1) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            OVER: begin
                if (!bus.enable) begin
                    state_n = IDLE;
                end else if (fall) begin
                    state_n = done_state;
                    cnt_n   = CNT_W'(1);
                end
            end
            DEAD: begin
`ifdef SIGNALWIDTH_DEADTIME_EN
                if (!bus.enable || (cnt >= deadtime)) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            width_q <= '0;
            wv_q    <= 1'b0;
            acc_q   <= 1'b0;
            rs_q    <= 1'b0;
            rl_q    <= 1'b0;
            busy_q  <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            s1      <= bus.din;
            s2      <= s1;
            s3      <= s2;
            state   <= state_n;
            cnt     <= cnt_n;
            width_q <= width_n;
            wv_q    <= wv_n;
            acc_q   <= acc_n;
            rs_q    <= rs_n;
            rl_q    <= rl_n;
            busy_q  <= (state_n != IDLE);
            pcnt_q  <= pcnt_q + PCNT_W'(acc_n);
        end
    end

    assign bus.width_out    = width_q;
    assign bus.width_valid  = wv_q;
    assign bus.accept       = acc_q;
    assign bus.reject_short = rs_q;
    assign bus.reject_long  = rl_q;
    assign bus.busy         = busy_q;
    assign bus.pulse_cnt    = pcnt_q;
endmodule

// File: tb/tb_signal_width_meter.sv
// tb/tb_signal_width_meter.sv - scoreboard bench for signal_width_meter (narrow pulse_cnt to exercise wrap)
module tb_signal_width_meter;
    localparam int CNT_W  = 10;
    localparam int PCNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [CNT_W-1:0] deadtime;

    always #5 clk = ~clk;

    signal_width_meter_if #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) bus ();

    signal_width_meter #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef SIGNALWIDTH_DEADTIME_EN
        .deadtime(deadtime),
`endif
        .bus     (bus.slave)
    );

    typedef struct {
        int w;
        bit a;
        bit s;
        bit l;
        int pc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int exp_pcnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int w, input bit a, input bit s, input bit l);
        exp_t e;
        if (a) exp_pcnt = (exp_pcnt + 1) % (1 << PCNT_W);
        e.w = w; e.a = a; e.s = s; e.l = l; e.pc = exp_pcnt;
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int high, input int low);
        bus.din = 1'b1;
        cyc(high);
        bus.din = 1'b0;
        cyc(low);
    endtask

    // monitor: every strobe must match the oldest expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.width_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", bus.width_out, -1);
                end else begin
                    e = q.pop_front();
                    chk("width_out", bus.width_out, e.w);
                    chk("accept", bus.accept, e.a);
                    chk("reject_short", bus.reject_short, e.s);
                    chk("reject_long", bus.reject_long, e.l);
                    chk("pulse_cnt", bus.pulse_cnt, e.pc);
                end
            end else if (rst_n === 1'b1) begin
                if (bus.accept || bus.reject_short || bus.reject_long)
                    chk("orphan_class_strobe", 1, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        deadtime      = '0;
        bus.din       = 1'b0;
        bus.enable    = 1'b0;
        bus.min_width = 10'd4;
        bus.max_width = 10'd20;
        cyc(4);
        chk("rst_width_out", bus.width_out, 0);
        chk("rst_width_valid", bus.width_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pulse_cnt", bus.pulse_cnt, 0);
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        cyc(3);

        // accepted pulse, busy idle afterwards
        push(10, 1, 0, 0);
        pulse(10, 6);
        chk("busy_after_accept", bus.busy, 0);

        // short
        push(2, 0, 1, 0);
        pulse(2, 6);

        // long: reported at cnt == max while still high, nothing at fall
        push(20, 0, 0, 1);
        bus.din = 1'b1;
        cyc(40);
        chk("busy_in_over", bus.busy, 1);
        cyc(10);
        bus.din = 1'b0;
        cyc(5);
        chk("busy_after_over", bus.busy, 0);

        // boundaries: width == max and width == min accept
        push(20, 1, 0, 0);
        pulse(20, 5);
        push(4, 1, 0, 0);
        pulse(4, 5);

        // back-to-back with one low cycle
        bus.min_width = 10'd1;
        bus.max_width = 10'd0;
        push(6, 1, 0, 0);
        push(8, 1, 0, 0);
        pulse(6, 1);
        pulse(8, 6);

        // min > max: never accept
        bus.min_width = 10'd10;
        bus.max_width = 10'd5;
        push(5, 0, 0, 1);
        pulse(7, 6);
        push(3, 0, 1, 0);
        pulse(3, 6);
        push(5, 0, 1, 0);
        pulse(5, 6);

        // min = 0 accepts a single-cycle pulse
        bus.min_width = 10'd0;
        bus.max_width = 10'd0;
        push(1, 1, 0, 0);
        pulse(1, 6);

        // enable dropped at cnt 5
        bus.din = 1'b1;
        cyc(7);
        chk("busy_cnt5", bus.busy, 1);
        bus.enable = 1'b0;
        cyc(1);
        chk("busy_after_disable", bus.busy, 0);
        bus.din = 1'b0;
        cyc(5);
        bus.enable = 1'b1;
        cyc(2);

        // reset at cnt 5
        bus.din = 1'b1;
        cyc(7);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_width_out", bus.width_out, 0);
        chk("midrst_pulse_cnt", bus.pulse_cnt, 0);
        chk("midrst_width_valid", bus.width_valid, 0);
        bus.din = 1'b0;
        cyc(4);
        rst_n    = 1'b1;
        exp_pcnt = 0;
        cyc(3);

        // pulse_cnt wraps
        bus.min_width = 10'd1;
        for (int i = 0; i < 17; i++) begin
            push(3, 1, 0, 0);
            pulse(3, 2);
        end
        cyc(6);
        chk("pulse_cnt_wrapped", bus.pulse_cnt, 1);

`ifdef SIGNALWIDTH_DEADTIME_EN
        deadtime = 10'd10;
        push(5, 1, 0, 0);
        pulse(5, 4);
        chk("busy_in_dead", bus.busy, 1);
        pulse(5, 20);
        push(5, 1, 0, 0);
        push(5, 1, 0, 0);
        pulse(5, 15);
        pulse(5, 20);
        deadtime = 10'd0;
`endif

        cyc(10);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
